decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage between fetch and execute.
- Accepts one instruction word plus its PC per valid/ready handshake.
- Extracts register indices and function fields, and produces a single sign-extended XLEN-wide immediate with its format tag.
- Flags illegal encodings.
- A two-entry output skid buffer gives full throughput under back-pressure.

## Interface
- XLEN, 32, datapath/immediate/PC width; legal values 32 or 64
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  drop all buffered instructions; highest priority
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  PC passed through
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when the format does not use the field
- out_funct3  out  3  instr[14:12]; 0 for U/J
- out_funct7  out  7  instr[31:25] for R-type, else 0
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type
- out_imm_type  out  3  imm_type_e: NONE, I, S, B, U, J
- out_illegal  out  1  encoding not supported

## Operation
- Supported opcodes: OP 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
- Immediates:
  - I: sext(i[31:20])
  - S: sext({i[31:25], i[11:7]})
  - B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0})
  - U: sext({i[31:12], 12'b0})
  - J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0})
  - Sign bit is always i[31]; it is extended to XLEN.
- Field usage per format:
  - R: rd, rs1, rs2
  - I: rd, rs1
  - S/B: rs1, rs2
  - U/J: rd
  - All unused fields are 0.
- Unknown opcode: all fields 0, imm_type NONE, illegal=1 (when enabled).
- Handshake:
  - Transfer occurs when valid&&ready on either side.
  - out_* are stable while out_valid&&!out_ready.
  - Strict in-order.
- Buffer:
  - Main register M drives out_*.
  - Skid register K captures an accepted instruction when M is full and not draining.
  - in_ready = !K.valid && !flush && !rst.
  - When M drains, K moves to M in the same edge.
  - Simultaneous accept + drain with K empty: new entry goes straight into M.
- Flush: on the edge where flush=1, M.valid and K.valid clear and any concurrent in_valid is discarded.
- Reset: M.valid=K.valid=0; every out_* is 0; in_ready=0 while rst=1 and 1 on the first cycle after release. Reset mid-stream discards both entries.

## Timing
- Latency: 1 cycle, from accepting edge to out_valid=1 with decoded fields.
- Throughput: 1 instruction/cycle while out_ready=1.
- After one stall cycle (out_ready=0), in_ready falls only once K is occupied, i.e. up to 2 instructions are held.
- in_ready depends only on registered state, flush and rst; there is no combinational path from out_ready.
- out_* are registered and have no combinational path from in_*.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined: out_illegal=1 for any of:
  - instr[1:0]!=2'b11
  - unknown opcode
  - OP with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}
  - OP_IMM shift whose upper imm bits are non-zero (except bit 30 for SRAI); shamt[5] is allowed only when XLEN=64
  - BRANCH funct3 010/011
  - STORE funct3 >= 011 when XLEN=32, or > 011 when XLEN=64
  - LOAD funct3 011/110/111 when XLEN=32, or 111 when XLEN=64
  - JALR funct3 != 000
- DECODE_ILLEGAL_CHECK_EN undefined: out_illegal tied to 0 and no check logic is built; field extraction is unchanged.

## Structure
- decode_pkg holds:
  - opcode localparams
  - imm_type_e enum
  - decoded_t packed struct (all out_* except valid), parametrised by XLEN via a typedef in the module
  - function sext
- Sub-module imm_gen (combinational: instr, opcode -> imm, imm_type) is instantiated once.
- Field decode feeds a decoded_t that is written into M/K.

## Test plan
- ADDI x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle: rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, imm_type=I, illegal=0.
- SW x1,12(x2) (0x00112623) then BEQ x0,x0,-4 (0xFE000EE3) back-to-back -> imm=12 (S, rd=0), then imm=0xFFFFFFFC (B); LUI x5,0x12345 (0x123452B7) -> imm=0x12345000, rd=5.
- Three instructions sent while out_ready=0 -> first two accepted, in_ready=0 on the third; out_ready=1 releases them in order with no loss or duplication.
- Word 0x00000000 and OP with funct7=0000001 -> illegal=1 when DECODE_ILLEGAL_CHECK_EN is defined, 0 when it is undefined.
- M and K full, flush=1 with in_valid=1 -> next cycle out_valid=0 and the in_valid instruction is not emitted.
- rst pulsed asynchronously mid-stream -> out_valid and all out_* go to 0 immediately; the first instruction after release emerges with 1-cycle latency.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, immediate format tags, decoded fields and sign extension
// Contents: OPC_* opcode localparams, imm_type_e, dec_fields_t (XLEN-independent
// part of a decoded instruction), sext() 32->64 sign extension.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // PC and immediate are XLEN wide, so they are added around this struct
    // by a module-local typedef in decode_stage.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        imm_type_e  imm_type;
        logic       illegal;
    } dec_fields_t;

    function automatic logic [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch-side and execute-side handshake bundle of decode_stage
// master: fetch/execute side (drives in_*, out_ready); slave: decode_stage.
// Signals: in_valid/in_ready/in_instr/in_pc, out_valid/out_ready/out_pc/out_opcode/
// out_rd/out_rs1/out_rs2/out_funct3/out_funct7/out_imm/out_imm_type/out_illegal.
interface decode_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_imm_type;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_imm_type, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_imm_type, out_illegal
    );
endinterface

// File: rtl/decode_imm_gen.sv
// rtl/decode_imm_gen.sv - combinational immediate extraction and format tagging
// Ports: instr[31:7] (instruction above the opcode), opcode[6:0] -> imm[XLEN-1:0], imm_type.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [6:0]      opcode,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);

    logic [31:0] imm32;

    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                imm_type = IMM_I;
                imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type = IMM_U;
                imm32    = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // imm32 is already sign-extended from instr[31]; RV64 widens it further.
    if (XLEN == 64) begin : g_rv64
        assign imm = sext(imm32);
    end else begin : g_rv32
        assign imm = imm32;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I/RV64I decode stage with two-entry output skid buffer
// Ports: clk, rst (async, active-high), flush, bus (decode_if.slave: fetch in_*, execute out_*).
// Option: DECODE_ILLEGAL_CHECK_EN builds the illegal-encoding checker; otherwise out_illegal=0.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    decode_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_fields_t     f;
    } decoded_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            illegal;
    decoded_t        dec;

    assign opc = bus.in_instr[6:0];
    assign f3  = bus.in_instr[14:12];
    assign f7  = bus.in_instr[31:25];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (bus.in_instr[31:7]),
        .opcode   (opc),
        .imm      (imm),
        .imm_type (imm_type)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Every supported opcode ends in 2'b11, so a compressed/invalid low pair
    // lands in the default arm together with unknown opcodes.
    always_comb begin
        illegal = 1'b0;
        case (opc)
            OPC_OP: begin
                if (f7 != 7'b0000000 && f7 != 7'b0100000)
                    illegal = 1'b1;
                else if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                // instr[25] is shamt[5], only meaningful on RV64.
                if (f3 == 3'b001)
                    illegal = (bus.in_instr[31:26] != 6'b0) || (XLEN == 32 && bus.in_instr[25]);
                else if (f3 == 3'b101)
                    illegal = ({bus.in_instr[31], bus.in_instr[29:26]} != 5'b0) ||
                              (XLEN == 32 && bus.in_instr[25]);
            end
            OPC_BRANCH: illegal = (f3 == 3'b010) || (f3 == 3'b011);
            OPC_STORE:  illegal = (XLEN == 32) ? (f3 >= 3'b011) : (f3 > 3'b011);
            OPC_LOAD:   illegal = (XLEN == 32) ? (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                                               : (f3 == 3'b111);
            OPC_JALR:   illegal = (f3 != 3'b000);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: illegal = 1'b0;
            default:    illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    // Fields a format does not use stay 0; imm_type NONE covers both R-type
    // and unknown opcodes, told apart by the opcode.
    always_comb begin
        dec            = '0;
        dec.pc         = bus.in_pc;
        dec.imm        = imm;
        dec.f.opcode   = opc;
        dec.f.imm_type = imm_type;
        dec.f.illegal  = illegal;
        case (imm_type)
            IMM_NONE: begin
                if (opc == OPC_OP) begin
                    dec.f.rd     = bus.in_instr[11:7];
                    dec.f.rs1    = bus.in_instr[19:15];
                    dec.f.rs2    = bus.in_instr[24:20];
                    dec.f.funct3 = f3;
                    dec.f.funct7 = f7;
                end
            end
            IMM_I: begin
                dec.f.rd     = bus.in_instr[11:7];
                dec.f.rs1    = bus.in_instr[19:15];
                dec.f.funct3 = f3;
            end
            IMM_S, IMM_B: begin
                dec.f.rs1    = bus.in_instr[19:15];
                dec.f.rs2    = bus.in_instr[24:20];
                dec.f.funct3 = f3;
            end
            IMM_U, IMM_J: dec.f.rd = bus.in_instr[11:7];
            default: ;
        endcase
    end

    // M drives the outputs; K only fills while M is stalled, so K can hold an
    // entry only while M is also full.
    decoded_t m_q, k_q;
    logic     m_valid, k_valid;
    logic     accept, drain;

    assign bus.in_ready = !k_valid && !flush && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = m_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
            m_q     <= '0;
            k_q     <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
        end else if (!m_valid || drain) begin
            // accept is impossible while K holds an entry (in_ready is low)
            if (k_valid) begin
                m_q     <= k_q;
                m_valid <= 1'b1;
                k_valid <= 1'b0;
            end else if (accept) begin
                m_q     <= dec;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            k_q     <= dec;
            k_valid <= 1'b1;
        end
    end

    assign bus.out_valid    = m_valid;
    assign bus.out_pc       = m_q.pc;
    assign bus.out_imm      = m_q.imm;
    assign bus.out_opcode   = m_q.f.opcode;
    assign bus.out_rd       = m_q.f.rd;
    assign bus.out_rs1      = m_q.f.rs1;
    assign bus.out_rs2      = m_q.f.rs2;
    assign bus.out_funct3   = m_q.f.funct3;
    assign bus.out_funct7   = m_q.f.funct7;
    assign bus.out_imm_type = m_q.f.imm_type;
    assign bus.out_illegal  = m_q.f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector self-checking bench for decode_stage (XLEN=32)
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    decode_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  ty;
        logic        ill;
    } vec_t;

    vec_t vt [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        //            instr         rd    rs1   rs2   f3    f7     imm            ty    ill
        vt[0] = '{32'hFFF10093, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 3'd1, 1'b0}; // ADDI x1,x2,-1
        vt[1] = '{32'h00112623, 5'd0, 5'd2, 5'd1, 3'd2, 7'h00, 32'h0000000C, 3'd2, 1'b0}; // SW x1,12(x2)
        vt[2] = '{32'hFE000EE3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 3'd3, 1'b0}; // BEQ x0,x0,-4
        vt[3] = '{32'h123452B7, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 3'd4, 1'b0}; // LUI x5,0x12345
        vt[4] = '{32'h008000EF, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 3'd5, 1'b0}; // JAL x1,+8
        vt[5] = '{32'h402081B3, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 3'd0, 1'b0}; // SUB x3,x1,x2
        vt[6] = '{32'h022081B3, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 32'h00000000, 3'd0, ILL};  // OP funct7=1
        vt[7] = '{32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd0, ILL};  // all-zero word

        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // reset state
        repeat (2) tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_imm", bus.out_imm, 32'h0);
        check("rst_out_rd", bus.out_rd, 5'd0);
        check("rst_out_imm_type", bus.out_imm_type, 3'd0);
        check("rst_out_illegal", bus.out_illegal, 1'b0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1'b1);

        // back-to-back decode, one instruction per cycle, 1-cycle latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].instr, 32'h1000 + 32'(4 * i));
            tick();
            check($sformatf("v%0d_valid", i), bus.out_valid, 1'b1);
            check($sformatf("v%0d_pc", i), bus.out_pc, 32'h1000 + 32'(4 * i));
            check($sformatf("v%0d_opcode", i), bus.out_opcode, {57'b0, vt[i].instr[6:0]});
            check($sformatf("v%0d_rd", i), bus.out_rd, vt[i].rd);
            check($sformatf("v%0d_rs1", i), bus.out_rs1, vt[i].rs1);
            check($sformatf("v%0d_rs2", i), bus.out_rs2, vt[i].rs2);
            check($sformatf("v%0d_funct3", i), bus.out_funct3, vt[i].f3);
            check($sformatf("v%0d_funct7", i), bus.out_funct7, vt[i].f7);
            check($sformatf("v%0d_imm", i), bus.out_imm, vt[i].imm);
            check($sformatf("v%0d_imm_type", i), bus.out_imm_type, vt[i].ty);
            check($sformatf("v%0d_illegal", i), bus.out_illegal, vt[i].ill);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("b2b_drained", bus.out_valid, 1'b0);

        // back-pressure: two held, third refused, released in order
        bus.out_ready = 1'b0;
        drive(1'b1, vt[0].instr, 32'h200);
        tick();
        check("bp_ready_after_1", bus.in_ready, 1'b1);
        check("bp_pc_1", bus.out_pc, 32'h200);
        drive(1'b1, vt[1].instr, 32'h204);
        tick();
        check("bp_ready_after_2", bus.in_ready, 1'b0);
        drive(1'b1, vt[3].instr, 32'h208);
        tick();
        check("bp_stall_valid", bus.out_valid, 1'b1);
        check("bp_stall_pc", bus.out_pc, 32'h200);
        check("bp_stall_imm", bus.out_imm, 32'hFFFFFFFF);
        check("bp_stall_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_rel_pc_2", bus.out_pc, 32'h204);
        check("bp_rel_imm_2", bus.out_imm, 32'h0000000C);
        check("bp_rel_ready", bus.in_ready, 1'b1);
        tick();
        check("bp_rel_pc_3", bus.out_pc, 32'h208);
        check("bp_rel_valid_3", bus.out_valid, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("bp_done", bus.out_valid, 1'b0);

        // flush with M and K full and a concurrent in_valid
        bus.out_ready = 1'b0;
        drive(1'b1, vt[0].instr, 32'h300);
        tick();
        drive(1'b1, vt[1].instr, 32'h304);
        tick();
        flush = 1'b1;
        drive(1'b1, vt[4].instr, 32'h308);
        #1;
        check("fl_in_ready", bus.in_ready, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl_out_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("fl_nothing_emitted", bus.out_valid, 1'b0);

        // asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        drive(1'b1, vt[3].instr, 32'h380);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("ar_pre_valid", bus.out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", bus.out_valid, 1'b0);
        check("ar_out_pc", bus.out_pc, 32'h0);
        check("ar_out_imm", bus.out_imm, 32'h0);
        check("ar_out_rd", bus.out_rd, 5'd0);
        check("ar_in_ready", bus.in_ready, 1'b0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, vt[3].instr, 32'h400);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("ar_first_valid", bus.out_valid, 1'b1);
        check("ar_first_pc", bus.out_pc, 32'h400);
        check("ar_first_imm", bus.out_imm, 32'h12345000);
        check("ar_first_rd", bus.out_rd, 5'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
